requant_scheduler: RTL and testbench
====================================

Name: requant_scheduler

Overview:
- Shares one 2-stage requantization datapath between NUM_CH accumulator streams, one per output channel of a conv/FC layer.
- Arbitrates the streams round-robin and applies a per-channel multiplier/shift from a runtime-writable table.
- Saturates results to int8, tags each with its channel id, and buffers them in a small output FIFO with ready/valid backpressure.
- Sits between the accumulator array and the activation/pooling stage.

Parameters:
NUM_CH, 4, number of requesting channels (power of 2, >=2)
CH_W, 2, channel index width, log2(NUM_CH)
IN_W, 32, signed accumulator width
OUT_W, 8, signed output width
MULT_W, 16, unsigned multiplier width
SHIFT_W, 5, right-shift amount width (0..31)
DEFAULT_MULT, 116, multiplier loaded into every channel at reset
DEFAULT_SHIFT, 16, shift loaded into every channel at reset
FIFO_DEPTH, 4, output FIFO entries (power of 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_CH  per-channel accumulator valid
req_data  in  NUM_CH*IN_W  packed signed accumulators, channel i at [i*IN_W +: IN_W]
req_ready  out  NUM_CH  per-channel accept, at most one bit high
cfg_we  in  1  table write strobe
cfg_ch  in  CH_W  channel to write
cfg_mult  in  MULT_W  new multiplier
cfg_shift  in  SHIFT_W  new shift
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accept
out_data  out  OUT_W  signed saturated result
out_ch  out  CH_W  channel of out_data
busy  out  1  any item in pipeline or FIFO
sat_cnt  out  16  count of clipped results, saturates at 16'hFFFF

Behaviour:
- Reset: sync, active-high, dominant over all other inputs. Drives out_valid=0, out_data=0, out_ch=0, busy=0, sat_cnt=0 and req_ready=0 while rst=1. Clears RR pointer to 0, pipeline valids and FIFO pointers. Loads all table entries with DEFAULT_MULT/DEFAULT_SHIFT. A reset mid-operation discards in-flight and buffered items silently.
- Credit: credit_ok = (fifo_count + s1_valid) < FIFO_DEPTH. It uses registered counts only; a same-cycle pop returns no credit.
- Arbitration: candidate = lowest index >= rr_ptr with req_valid, wrapping modulo NUM_CH. req_ready[candidate] = credit_ok. Transfer = req_valid & req_ready. On transfer, rr_ptr <= candidate+1 (wraps). No transfer leaves rr_ptr unchanged. Throughput is 1 item/cycle.
- Table: on cfg_we, entry cfg_ch is updated at the edge. A grant in the same cycle reads the pre-write value. Parameters are captured into stage 1 at grant, so in-flight items are never affected by later writes.
- Stage 1 (transfer edge k): prod = req_data[cand] * {0, mult}. This is a signed IN_W x unsigned MULT_W multiply with an IN_W+MULT_W+1 bit result. Stage 1 also registers ch and shift.
- Stage 2 (edge k+1): sh = prod >>> shift (arithmetic, floor). Result is 127 if sh>127, -128 if sh<-128, else sh[OUT_W-1:0]. The item is written into the FIFO with ch. If clipped, sat_cnt increments unless it is already 16'hFFFF.
- FIFO: first-word fall-through. out_valid=1 in the cycle after edge k+1 when the FIFO was empty, so latency is 2 edges. Pop on out_valid & out_ready. Simultaneous push and pop holds the count. Overflow cannot occur by construction; verification asserts this.
- Order: results leave in grant order.
- busy = s1_valid | (fifo_count != 0).

Decomposition:
- Package requant_pkg: DEFAULT_MULT, DEFAULT_SHIFT, SAT_MAX=127, SAT_MIN=-128, widths, and a function clip_int8.
- Sub-module requant_core: 2-stage multiply/shift/saturate datapath with runtime mult/shift and a sideband ch tag; outputs valid, data, ch and clipped flag.
- Arbiter, table and FIFO stay in requant_scheduler.

Test Plan:
- Defaults after reset: ch0 sends -50000 with out_ready=1 -> out_data=-89, out_ch=0, out_valid exactly 2 edges after accept; sat_cnt=0.
- Saturation: ch1 sends 2000000, then ch1 sends -2000000 -> outputs 127 then -128; sat_cnt=2. ch1 sends 100000 -> 127; sat_cnt=3.
- Round-robin: all 4 req_valid held high, out_ready=1 -> grants and out_ch sequence 0,1,2,3,0,1,... with one accept per cycle. Dropping ch2's valid -> sequence 0,1,3,0,1,3.
- Backpressure: out_ready=0, all valid -> exactly 4 transfers, then req_ready=0. Raising out_ready -> 4 results in grant order, then flow resumes; no loss or duplication.
- Config race: cfg_we ch2 mult=1 shift=0 in the same cycle as a ch2 grant of 5 -> output 0 (old params). Next ch2 grant of 5 -> output 5.
- Reset mid-op: fill FIFO with 3 entries, pulse rst for 1 cycle -> next cycle out_valid=0, busy=0, sat_cnt=0, rr_ptr=0. Table is back to 116/16: ch0 sends 1000000 -> 127.

Source files
------------

// File: rtl/requant_pkg.sv
// Shared constants, result type and int8 clip helper for the requant scheduler.
package requant_pkg;

  localparam int unsigned NUM_CH_DEF     = 4;
  localparam int unsigned CH_W_DEF       = 2;
  localparam int unsigned IN_W_DEF       = 32;
  localparam int unsigned OUT_W_DEF      = 8;
  localparam int unsigned MULT_W_DEF     = 16;
  localparam int unsigned SHIFT_W_DEF    = 5;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  localparam int unsigned DEFAULT_MULT  = 116;
  localparam int unsigned DEFAULT_SHIFT = 16;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  // Working width of the clip helper; any product width up to this is accepted.
  localparam int unsigned CLIP_W = 64;

  typedef struct packed {
    logic       clipped;
    logic [7:0] data;
  } clip_t;

  function automatic clip_t clip_int8(input logic signed [CLIP_W-1:0] v);
    clip_t r;
    r.clipped = 1'b0;
    r.data    = v[7:0];
    if (v > CLIP_W'(SAT_MAX)) begin
      r.clipped = 1'b1;
      r.data    = 8'h7F;
    end else if (v < CLIP_W'(SAT_MIN)) begin
      r.clipped = 1'b1;
      r.data    = 8'h80;
    end
    return r;
  endfunction

endpackage

// File: rtl/requant_core.sv
// Two-stage requant datapath: multiply on accept, shift/saturate on the next edge.
module requant_core
  import requant_pkg::*;
#(
  parameter int unsigned IN_W    = IN_W_DEF,
  parameter int unsigned MULT_W  = MULT_W_DEF,
  parameter int unsigned SHIFT_W = SHIFT_W_DEF,
  parameter int unsigned CH_W    = CH_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [IN_W-1:0]    in_data,
  input  logic [MULT_W-1:0]         in_mult,
  input  logic [SHIFT_W-1:0]        in_shift,
  input  logic [CH_W-1:0]           in_ch,
  output logic                      out_valid,
  output logic [OUT_W-1:0]          out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_clipped
);

  localparam int unsigned PROD_W = IN_W + MULT_W + 1;

  logic                     s1_valid;
  logic signed [PROD_W-1:0] s1_prod;
  logic [SHIFT_W-1:0]       s1_shift;
  logic [CH_W-1:0]          s1_ch;

  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] sh;
  clip_t                    res;

  // Signed accumulator times zero-extended unsigned multiplier.
  always_comb begin
    prod_d = PROD_W'(in_data) * PROD_W'($signed({1'b0, in_mult}));
  end

  // Stage-1 valid with reset; datapath registers only load on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
    end
    if (in_valid) begin
      s1_prod  <= prod_d;
      s1_shift <= in_shift;
      s1_ch    <= in_ch;
    end
  end

  // Stage 2: arithmetic (floor) shift then clip to int8; consumed at the next edge.
  always_comb begin
    sh  = s1_prod >>> s1_shift;
    res = clip_int8(CLIP_W'(sh));
  end

  assign out_valid   = s1_valid;
  assign out_data    = OUT_W'(res.data);
  assign out_ch      = s1_ch;
  assign out_clipped = res.clipped;

endmodule

// File: rtl/requant_scheduler.sv
// Round-robin requant scheduler: per-channel table, shared datapath, FWFT output FIFO.
module requant_scheduler
  import requant_pkg::*;
#(
  parameter int unsigned NUM_CH        = NUM_CH_DEF,
  parameter int unsigned CH_W          = CH_W_DEF,
  parameter int unsigned IN_W          = IN_W_DEF,
  parameter int unsigned OUT_W         = OUT_W_DEF,
  parameter int unsigned MULT_W        = MULT_W_DEF,
  parameter int unsigned SHIFT_W       = SHIFT_W_DEF,
  parameter int unsigned DEFAULT_MULT  = requant_pkg::DEFAULT_MULT,
  parameter int unsigned DEFAULT_SHIFT = requant_pkg::DEFAULT_SHIFT,
  parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*IN_W-1:0]   req_data,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [MULT_W-1:0]        cfg_mult,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     busy,
  output logic [15:0]              sat_cnt
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [MULT_W-1:0]  mult_tbl  [NUM_CH];
  logic [SHIFT_W-1:0] shift_tbl [NUM_CH];

  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] cand;
  logic [CH_W-1:0] idx;
  logic            found;
  logic            credit_ok;
  logic            grant;

  logic             core_valid;
  logic [OUT_W-1:0] core_data;
  logic [CH_W-1:0]  core_ch;
  logic             core_clipped;

  logic [OUT_W-1:0] data_mem [FIFO_DEPTH];
  logic [CH_W-1:0]  ch_mem   [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  logic [15:0]      sat_q;

  // Pick the first requesting channel at or after rr_ptr, wrapping.
  always_comb begin
    cand  = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = rr_ptr + CH_W'(i);
      if (!found && req_valid[idx]) begin
        cand  = idx;
        found = 1'b1;
      end
    end
  end

  // Credit counts only registered occupancy, so a pop this cycle frees nothing yet.
  always_comb begin
    credit_ok = (fifo_count + CNT_W'(core_valid)) < CNT_W'(FIFO_DEPTH);
    grant     = found && credit_ok && !rst;
    req_ready = grant ? (NUM_CH'(1) << cand) : '0;
  end

  // Round-robin pointer advances past the granted channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= cand + CH_W'(1);
    end
  end

  // Per-channel multiplier/shift table; a same-cycle grant sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mult_tbl[i]  <= MULT_W'(DEFAULT_MULT);
        shift_tbl[i] <= SHIFT_W'(DEFAULT_SHIFT);
      end
    end else if (cfg_we) begin
      mult_tbl[cfg_ch]  <= cfg_mult;
      shift_tbl[cfg_ch] <= cfg_shift;
    end
  end

  requant_core #(
    .IN_W    (IN_W),
    .MULT_W  (MULT_W),
    .SHIFT_W (SHIFT_W),
    .CH_W    (CH_W),
    .OUT_W   (OUT_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (grant),
    .in_data     (req_data[cand*IN_W +: IN_W]),
    .in_mult     (mult_tbl[cand]),
    .in_shift    (shift_tbl[cand]),
    .in_ch       (cand),
    .out_valid   (core_valid),
    .out_data    (core_data),
    .out_ch      (core_ch),
    .out_clipped (core_clipped)
  );

  assign push = core_valid;
  assign pop  = out_valid && out_ready;

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= core_data;
      ch_mem[wr_ptr]   <= core_ch;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop holds the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Saturating count of clipped results entering the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= '0;
    end else if (push && core_clipped && (sat_q != '1)) begin
      sat_q <= sat_q + 16'd1;
    end
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    out_valid = !rst && (fifo_count != '0);
    out_data  = rst ? '0 : data_mem[rd_ptr];
    out_ch    = rst ? '0 : ch_mem[rd_ptr];
    busy      = !rst && (core_valid || (fifo_count != '0));
    sat_cnt   = rst ? '0 : sat_q;
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_requant_scheduler.sv
// Scoreboard bench for requant_scheduler with a plain-arithmetic reference model.
module tb_requant_scheduler;

  localparam int NCH   = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_ch = '0;
  logic [15:0]  cfg_mult = '0;
  logic [4:0]   cfg_shift = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [7:0]   out_data;
  logic [1:0]   out_ch;
  logic         busy;
  logic [15:0]  sat_cnt;

  requant_scheduler #(
    .NUM_CH     (4),
    .CH_W       (2),
    .IN_W       (32),
    .OUT_W      (8),
    .MULT_W     (16),
    .SHIFT_W    (5),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mult  (cfg_mult),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .busy      (busy),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    int          val;
    int unsigned acc;
    bit          lat;
    bit          seen;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned accepted = 0;
  int unsigned popped = 0;
  int unsigned pop_base = 0;
  int          rr_m = 0;
  int          mult_m[NCH];
  int          shift_m[NCH];
  int          sat_m = 0;
  int          xfer_obs = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    rr_m = 0;
    sat_m = 0;
    accepted = 0;
    pop_base = popped;
    sbq.delete();
    for (int i = 0; i < NCH; i++) begin
      mult_m[i]  = 116;
      shift_m[i] = 16;
    end
  endfunction

  // One clock: inputs already driven; predict grant, check, then update model at the edge.
  task automatic tick();
    int          g;
    int          outstanding;
    logic [3:0]  exp_rdy;
    int unsigned acc_c;
    longint      p;
    int          v;
    bit          clipped;
    #1;
    acc_c = cyc;
    outstanding = int'(accepted) - int'(popped - pop_base);
    g = -1;
    if (!rst && outstanding < DEPTH) begin
      for (int i = 0; i < NCH; i++) begin
        int c;
        c = (rr_m + i) % NCH;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, (!rst && outstanding != 0) ? 1 : 0);
    if ((req_valid & req_ready) != 4'b0) xfer_obs++;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_sat_cnt", sat_cnt, 0);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        p = longint'($signed(req_data[g*32 +: 32])) * longint'(mult_m[g]);
        p = p >>> shift_m[g];
        clipped = (p > 127) || (p < -128);
        v = (p > 127) ? 127 : (p < -128) ? -128 : int'(p);
        sbq.push_back('{g, v, acc_c, outstanding == 0, 1'b0});
        if (clipped && sat_m < 65535) sat_m++;
        rr_m = (g + 1) % NCH;
        accepted++;
      end
      if (cfg_we) begin
        mult_m[cfg_ch]  = int'(cfg_mult);
        shift_m[cfg_ch] = int'(cfg_shift);
      end
    end
    #1;
  endtask

  // Monitor: compare the FIFO head against the scoreboard whenever it is popped.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          if (sbq[0].lat && !sbq[0].seen) begin
            chk("latency_2_edges", cyc, sbq[0].acc + 2);
            sbq[0].seen = 1'b1;
          end
          if (out_ready) begin
            chk("out_data", $signed(out_data), sbq[0].val);
            chk("out_ch", out_ch, sbq[0].ch);
            void'(sbq.pop_front());
            popped++;
          end
        end
      end
    end
  end

  task automatic set_data(int ch, int val);
    req_data[ch*32 +: 32] = val;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NCH; i++) set_data(i, $signed($urandom) >>> $urandom_range(0, 31));
  endtask

  task automatic idle(int n);
    req_valid = '0;
    cfg_we = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send1(int ch, int val);
    set_data(ch, val);
    req_valid = 4'(1 << ch);
    tick();
    req_valid = '0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Defaults: -50000 * 116 >>> 16 = -89
    send1(0, -50000);
    idle(4);
    chk("sat_cnt_default", sat_cnt, sat_m);

    // Saturation both directions, then another clip
    send1(1, 2000000);
    send1(1, -2000000);
    idle(4);
    chk("sat_cnt_two", sat_cnt, sat_m);
    send1(1, 100000);
    idle(4);
    chk("sat_cnt_three", sat_cnt, sat_m);

    // Round-robin with all requesting, then with ch2 dropped
    req_valid = 4'hF;
    repeat (12) begin rand_data(); tick(); end
    req_valid = 4'b1011;
    repeat (9) begin rand_data(); tick(); end
    idle(4);

    // Backpressure: exactly DEPTH transfers, then stall, then resume
    out_ready = 1'b0;
    xfer_obs = 0;
    req_valid = 4'hF;
    repeat (8) begin rand_data(); tick(); end
    chk("bp_transfers", xfer_obs, DEPTH);
    out_ready = 1'b1;
    repeat (10) begin rand_data(); tick(); end
    idle(4);

    // Config write racing a grant on the same channel
    set_data(2, 5);
    req_valid = 4'b0100;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mult = 16'd1; cfg_shift = 5'd0;
    tick();
    idle(3);
    send1(2, 5);
    idle(4);

    // Random traffic with random backpressure and table writes
    repeat (400) begin
      req_valid = 4'($urandom);
      rand_data();
      out_ready = ($urandom % 4) != 0;
      cfg_we = ($urandom % 16) == 0;
      cfg_ch = 2'($urandom);
      cfg_mult = 16'($urandom);
      cfg_shift = 5'($urandom);
      tick();
    end
    out_ready = 1'b1;
    idle(8);
    chk("sat_cnt_random", sat_cnt, sat_m);

    // Reset mid-operation with three buffered results
    out_ready = 1'b0;
    req_valid = 4'b0001;
    repeat (3) begin rand_data(); tick(); end
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sat_cnt", sat_cnt, 0);
    out_ready = 1'b1;
    rand_data();
    set_data(0, 1000000);
    req_valid = 4'hF;
    tick();
    idle(4);

    // Drain with a bounded wait
    out_ready = 1'b1;
    for (int i = 0; i < 30 && sbq.size() != 0; i++) idle(1);
    chk("drain_empty", sbq.size(), 0);
    chk("sat_cnt_final", sat_cnt, sat_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
